rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 4:1 multiplexer datapath.
- Four requesters compete for the single output `f`.
- The block owns the 2-bit mux select `s` and issues one-hot grants.
- The winner holds the mux until it drops its request, then priority rotates past it.
- Sits between requester logic and the shared output path.

---
 rtl/rr_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_mux_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_pkg
// Brief    : Shared constants, state type and helpers for the round-robin
//            4:1 mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Expand a requester index into a one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        onehot      = '0;
        onehot[sel] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational circular priority search. Returns the first set
//            bit of mask visiting start, start+1, ... (mod NUM_REQ).
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [SEL_W-1:0]   start,
    input  logic [NUM_REQ-1:0] mask,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [SEL_W-1:0] cand;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Brief    : Round-robin arbiter owning the select of a shared 4:1 mux.
//            A grantee keeps the mux until it drops its request; priority
//            then rotates past it, with back-to-back regrant when another
//            requester is waiting.
//            Optional macro RR_MUX_ARBITER_HOLD_LIMIT_EN caps a contended
//            grant at MAX_HOLD cycles.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] w,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [SEL_W-1:0]      s,
    output logic [DW-1:0]         f,
    output logic                  f_valid
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    state_t               state_q;
    logic [SEL_W-1:0]     ptr_q;
    logic [SEL_W-1:0]     s_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 fv_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [SEL_W-1:0]     w_next_sel;
    logic [SEL_W-1:0]     w_pick_start;
    logic [NUM_REQ-1:0]   w_pick_mask;
    logic [SEL_W-1:0]     w_pick_idx;
    logic                 w_pick_found;
    logic                 w_force;
    logic                 w_cnt_sat;

    // While granting, search starts past the grantee and excludes it, which
    // serves both the release case and the forced-rotation case.
    assign w_next_sel   = s_q + 2'd1;
    assign w_pick_start = (state_q == GRANT) ? w_next_sel : ptr_q;
    assign w_pick_mask  = req & ~((state_q == GRANT) ? onehot(s_q) : '0);
    assign w_cnt_sat    = (cnt_q == CNT_W'(MAX_HOLD));

`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
    assign w_force = req[s_q] && (cnt_q == CNT_W'(MAX_HOLD - 1)) && w_pick_found;
`else
    assign w_force = 1'b0;
`endif

    rr_pick u_pick (
        .start (w_pick_start),
        .mask  (w_pick_mask),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    // Arbitration FSM with registered grant, select and valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            s_q     <= '0;
            gnt_q   <= '0;
            fv_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pick_found) begin
                        s_q     <= w_pick_idx;
                        gnt_q   <= onehot(w_pick_idx);
                        fv_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end else begin
                        gnt_q <= '0;
                        fv_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (req[s_q] && !w_force) begin
                        if (!w_cnt_sat) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        ptr_q <= w_next_sel;
                        if (w_pick_found) begin
                            s_q   <= w_pick_idx;
                            gnt_q <= onehot(w_pick_idx);
                            cnt_q <= '0;
                        end else begin
                            gnt_q   <= '0;
                            fv_q    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    fv_q    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign s       = s_q;
    assign f_valid = fv_q;
    assign f       = w[s_q*DW +: DW];

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Brief    : Directed bench for rr_mux_arbiter with a reference model feeding
//            a scoreboard queue, plus fixed expectations for key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
    localparam int MH = 4;
`else
    localparam int MH = 8;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] w;
    logic [3:0] gnt;
    logic [1:0] s;
    logic [0:0] f;
    logic       f_valid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] s;
        logic       fv;
        logic       f;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (post-edge view)
    logic       m_busy;
    logic [1:0] m_ptr;
    logic [1:0] m_s;
    logic [3:0] m_gnt;
    logic       m_fv;
    int         m_cnt;

    rr_mux_arbiter #(.DW(1), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .w       (w),
        .gnt     (gnt),
        .s       (s),
        .f       (f),
        .f_valid (f_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v    = 4'b0000;
        v[i] = 1'b1;
        return v;
    endfunction

    // Returns {found, index}
    function automatic logic [2:0] pick(input logic [1:0] st, input logic [3:0] m);
        logic [1:0] i;
        for (int k = 0; k < 4; k++) begin
            i = st + 2'(k);
            if (m[i]) return {1'b1, i};
        end
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq);
        logic [2:0] p;
        logic [1:0] nx;
        if (r) begin
            m_busy = 1'b0; m_ptr = 2'd0; m_s = 2'd0;
            m_gnt  = 4'b0; m_fv  = 1'b0; m_cnt = 0;
        end else if (!m_busy) begin
            if (rq != 4'b0) begin
                p      = pick(m_ptr, rq);
                m_s    = p[1:0];
                m_gnt  = oh(int'(p[1:0]));
                m_fv   = 1'b1;
                m_cnt  = 0;
                m_busy = 1'b1;
            end else begin
                m_gnt = 4'b0;
                m_fv  = 1'b0;
            end
        end else begin
            nx = m_s + 2'd1;
            if (rq[m_s]) begin
                p = pick(nx, rq & ~oh(int'(m_s)));
`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
                if (m_cnt == MH - 1 && p[2]) begin
                    m_ptr = nx;
                    m_s   = p[1:0];
                    m_gnt = oh(int'(p[1:0]));
                    m_cnt = 0;
                end else if (m_cnt < MH) begin
                    m_cnt = m_cnt + 1;
                end
`else
                if (m_cnt < MH) m_cnt = m_cnt + 1;
`endif
            end else begin
                m_ptr = nx;
                p     = pick(nx, rq);
                if (p[2]) begin
                    m_s   = p[1:0];
                    m_gnt = oh(int'(p[1:0]));
                    m_cnt = 0;
                end else begin
                    m_gnt  = 4'b0;
                    m_fv   = 1'b0;
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    // One clock: drive at negedge, predict, then compare 1 time unit after posedge.
    task automatic cyc(input logic r, input logic [3:0] rq);
        exp_t e;
        @(negedge clk);
        reset = r;
        req   = rq;
        w     = 4'($urandom);
        model_step(r, rq);
        exp_q.push_back('{gnt: m_gnt, s: m_s, fv: m_fv, f: w[m_s]});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("sb_gnt", gnt, e.gnt);
        chk("sb_s", {2'b00, s}, {2'b00, e.s});
        chk("sb_fvalid", {3'b000, f_valid}, {3'b000, e.fv});
        chk("sb_f", {3'b000, f}, {3'b000, e.f});
    endtask

    int order[5] = '{0, 1, 2, 3, 0};
    int cur;

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        w     = 4'b0000;

        // 1: reset with all requests pending, then first grant
        cyc(1'b1, 4'b1111);
        cyc(1'b1, 4'b1111);
        chk("t1_rst_gnt", gnt, 4'b0000);
        chk("t1_rst_fv", {3'b000, f_valid}, 4'b0000);
        cyc(1'b0, 4'b1111);
        chk("t1_first_gnt", gnt, 4'b0001);

        // 2: hand over to requester 2, check data lane, then go idle
        @(negedge clk);
        cyc(1'b0, 4'b0100);
        chk("t2_gnt", gnt, 4'b0100);
        chk("t2_s", {2'b00, s}, 4'b0010);
        cyc(1'b0, 4'b0000);
        chk("t2_idle", gnt, 4'b0000);
        // ptr now 3: full request set must go to requester 3
        cyc(1'b0, 4'b1111);
        chk("t2_ptr3", gnt, 4'b1000);

        // 3: rotation with wrap-around, no idle gaps
        cur = 3;
        for (int g = 0; g < 5; g++) begin
            cyc(1'b0, 4'b1111);
            cyc(1'b0, 4'b1111);
            cyc(1'b0, 4'b1111 & ~oh(cur));
            chk("t3_order", gnt, oh(order[g]));
            chk("t3_valid", {3'b000, f_valid}, 4'b0001);
            cur = order[g];
        end

        // 4: reset mid-grant
        cyc(1'b0, 4'b0010);
        chk("t4_pre", gnt, 4'b0010);
        cyc(1'b1, 4'b1010);
        chk("t4_rst_gnt", gnt, 4'b0000);
        chk("t4_rst_s", {2'b00, s}, 4'b0000);
        cyc(1'b0, 4'b1010);
        chk("t4_after", gnt, 4'b0010);

        // 5: two-way contention, then a lone requester
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0011);
        chk("t5_first", gnt, 4'b0001);
        for (int k = 0; k < 4; k++) cyc(1'b0, 4'b0011);
`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
        chk("t5_rot1", gnt, 4'b0010);
`else
        chk("t5_rot1", gnt, 4'b0001);
`endif
        for (int k = 0; k < 4; k++) cyc(1'b0, 4'b0011);
        chk("t5_rot2", gnt, 4'b0001);
        for (int k = 0; k < 10; k++) cyc(1'b0, 4'b0001);
        chk("t5_alone", gnt, 4'b0001);
        chk("t5_alone_fv", {3'b000, f_valid}, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
